mem_dump_unit: RTL
==================

# mem_dump_unit

Post-run data-memory readout engine for alphacore. On a start pulse it reads a contiguous range of 32-bit words from the core's data memory through a synchronous read port. It serializes each word little-endian onto a byte stream with a valid/ready handshake. This gives benches and board-level harnesses the sorted-array results out of the core, the outbound counterpart to the word image loaded into memory at start-up.

## Interface
- ADDR_W, 8, word-address width; the memory holds 2^ADDR_W words (256)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; captured on accepted start
- word_count  in  ADDR_W+1  number of words, 0..2^ADDR_W; captured on accepted start
- mem_addr  out  ADDR_W  word address to data-memory read port
- mem_rd  out  1  read strobe to data memory
- mem_rdata  in  32  read data, valid exactly one cycle after mem_rd
- tx_data  out  8  output byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the dump completes

## Operation
- States: IDLE, READ, WAIT, SEND (plus CSUM with DUMP_CHECKSUM_EN).
- IDLE: start=1 captures base_addr into the address counter and word_count into the remaining counter, then goes to READ. If the captured count is 0, go instead straight to the done pulse: done=1 the next cycle with no reads and no bytes, then IDLE.
- READ: mem_rd=1, mem_addr=address counter; next state WAIT.
- WAIT: latch mem_rdata into the 32-bit shift register, byte index=0, go to SEND.
- SEND: tx_valid=1, tx_data = shift register byte [index], with index 0 = bits 7:0.
  - On handshake, index increments.
  - After byte 3 is accepted: address counter +1 (wraps mod 2^ADDR_W), remaining −1.
  - If remaining reaches 0: finish, meaning CSUM if enabled, else done. Otherwise go to READ.
- Finish: done=1 for one cycle, busy falls the same cycle, state returns to IDLE.
- start while busy is ignored; no queuing.
- mem_addr holds its last value when mem_rd=0. Only the mem_rd=1 cycles matter.

## Timing
- Reset values: state IDLE, mem_addr=0, mem_rd=0, tx_data=0x00, tx_valid=0, busy=0, done=0, all internal counters 0.
- Start accepted in cycle T:
  - busy=1 and mem_rd=1 in T+1.
  - Word latched in T+2.
  - First tx_valid in T+3.
- Each word costs 2 overhead cycles (READ, WAIT) plus 4 handshakes. With tx_ready held high, N words complete in 6N cycles, and done is asserted in cycle T+1+6N.
- While tx_valid=1 and tx_ready=0, tx_data and tx_valid are held stable. tx_valid never drops without a handshake.
- Address wrap: base 0xFE with count 4 reads 0xFE, 0xFF, 0x00, 0x01.
- A count of 256 with any base dumps the whole memory exactly once.
- rst asserted mid-dump returns everything to reset values immediately: no done pulse, and the partial stream is abandoned.
- start in the same cycle as done is ignored, because the unit is not yet in IDLE. It is accepted from the following cycle.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) of every byte accepted in the current dump is cleared on accepted start.
  - After the last data byte, state CSUM presents the sum as one extra byte under the same handshake. done pulses the cycle after that byte is accepted, and the 6N timing gains +1 cycle.
  - A count of 0 still produces no bytes.
- Not defined: no CSUM state, no sum register; the stream is data bytes only.

## Test plan
- Memory words 0..9 = 0,1,2,3,4,6,6,7,8,9 (sorted program result); start with base 0, count 10, tx_ready=1 -> 40 bytes 00 00 00 00 01 00 00 00 02 … 09 00 00 00, done at T+61. With DUMP_CHECKSUM_EN, a 41st byte 0x2E follows and done moves to T+62.
- Word 0x05 = 0xDEADBEEF, base 5, count 1, tx_ready toggling 1/0 each cycle -> bytes EF BE AD DE, each held stable while ready=0; exactly 4 handshakes, then one done pulse.
- Base 0xFE, count 4 -> mem_addr sequence FE, FF, 00, 01 on the mem_rd cycles.
- Count 0 -> no mem_rd, no tx_valid; done=1 at T+1; busy stays 0.
- rst pulsed after the second byte of a count-3 dump -> all outputs at reset values within the same cycle; a later start with base 0, count 1 streams correctly.
- start re-pulsed during busy -> ignored; the byte count and address sequence match the original request only.

Source files
------------

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: reads a contiguous range of 32-bit words from a synchronous-read data memory.
// It serializes each word little-endian (bits 7:0 first) onto a byte stream with a
// valid/ready handshake.
//
// Optional feature macro: DUMP_CHECKSUM_EN. When it is defined, an 8-bit running sum of the
// streamed bytes is sent as one trailing byte after the data.
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_i         asynchronous active-high reset
//   start_i       single-cycle dump request, honoured only in idle
//   base_addr_i   first word address, captured on accepted start
//   word_count_i  number of words (0..2^ADDR_W), captured on accepted start
//   mem_addr_o    word address to the memory read port
//   mem_rd_o      memory read strobe; data returns one cycle later
//   mem_rdata_i   memory read data
//   tx_data_o     output byte
//   tx_valid_o    tx_data_o valid
//   tx_ready_i    sink accepts byte when tx_valid_o && tx_ready_i
//   busy_o        dump in progress
//   done_o        one-cycle completion pulse
module mem_dump_unit #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   word_count_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StRead = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StSend = 3'd3;
  localparam logic [2:0] StDone = 3'd4;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] StCsum = 3'd5;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remain_q, remain_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;
  logic [7:0]        cur_byte;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  always_comb begin
    cur_byte = 8'h00;
    unique case (idx_q)
      2'd0: cur_byte = shift_q[7:0];
      2'd1: cur_byte = shift_q[15:8];
      2'd2: cur_byte = shift_q[23:16];
      2'd3: cur_byte = shift_q[31:24];
      default: cur_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
`ifdef DUMP_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d   = base_addr_i;
          remain_d = word_count_i;
`ifdef DUMP_CHECKSUM_EN
          sum_d    = 8'h00;
`endif
          // An empty request skips straight to the completion pulse.
          state_d  = (word_count_i == '0) ? StDone : StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        shift_d = mem_rdata_i;
        idx_d   = 2'd0;
        state_d = StSend;
      end
      StSend: begin
        if (tx_ready_i) begin
          idx_d = idx_q + 2'd1;
`ifdef DUMP_CHECKSUM_EN
          sum_d = sum_q + cur_byte;
`endif
          if (idx_q == 2'd3) begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - (ADDR_W + 1)'(1);
            if (remain_q == (ADDR_W + 1)'(1)) begin
`ifdef DUMP_CHECKSUM_EN
              state_d = StCsum;
`else
              state_d = StDone;
`endif
            end else begin
              state_d = StRead;
            end
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      StCsum: begin
        if (tx_ready_i) state_d = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      remain_q <= '0;
      shift_q  <= '0;
      idx_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  always_comb begin
    mem_addr_o = addr_q;
    mem_rd_o   = (state_q == StRead);
    done_o     = (state_q == StDone);
    tx_valid_o = (state_q == StSend);
    tx_data_o  = (state_q == StSend) ? cur_byte : 8'h00;
    busy_o     = (state_q == StRead) || (state_q == StWait) || (state_q == StSend);
`ifdef DUMP_CHECKSUM_EN
    if (state_q == StCsum) begin
      tx_valid_o = 1'b1;
      tx_data_o  = sum_q;
      busy_o     = 1'b1;
    end
`endif
  end

endmodule
